// File: rtl/uart_tx.sv
// uart_tx: UART transmitter (start, LSB-first data, stop) with a double-buffered holding register.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int CLOCKRATE = 100000000,
  parameter int BAUD = 115200,
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic                   tx_data_valid,
  output logic                   tx_data_ready,
  output logic                   tx_busy,
  output logic                   UART_TX,
  output logic [2:0]             current_state_debug
);
  localparam int M = CLOCKRATE / BAUD;
  localparam int CW = M > 1 ? $clog2(M) : 1;
  localparam int BW = WORD_LENGTH > 1 ? $clog2(WORD_LENGTH) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;
  state_t state, state_n;
  logic [CW-1:0] baud_cnt;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [WORD_LENGTH-1:0] shift_reg, shift_n, hold_reg;
  logic hold_full, line, line_n, load, hs, baud_done, last_bit;
`ifdef UART_TX_PARITY_EN
  logic parity, parity_n;
`endif
  assign tx_data_ready = reset && !hold_full;
  assign hs = tx_data_valid && tx_data_ready;
  assign baud_done = baud_cnt == CW'(M - 1);
  assign last_bit = bit_cnt == BW'(WORD_LENGTH - 1);
  assign tx_busy = state != IDLE;
  assign UART_TX = line;
  assign current_state_debug = state;
  // A held word launches straight out of IDLE or out of STOP with no idle clock
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    shift_n = shift_reg;
    load = 1'b0;
    case (state)
      IDLE: if (hold_full) begin
        load = 1'b1;
        state_n = START;
      end
      START: if (baud_done) begin
        state_n = DATA;
        bit_n = '0;
      end
      DATA: if (baud_done) begin
        if (last_bit)
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        else begin
          bit_n = bit_cnt + 1'b1;
          shift_n = shift_reg >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_done) state_n = STOP;
`endif
      STOP: if (baud_done) begin
        load = hold_full;
        state_n = hold_full ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (load) shift_n = hold_reg;
`ifdef UART_TX_PARITY_EN
    parity_n = load ? ^hold_reg : parity;
    line_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? parity_n : 1'b1;
`else
    line_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      hold_reg <= '0;
      hold_full <= 1'b0;
      line <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state <= state_n;
      baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + 1'b1;
      bit_cnt <= bit_n;
      shift_reg <= shift_n;
      hold_reg <= hs ? tx_data : hold_reg;
      hold_full <= hs || (hold_full && !load);
      line <= line_n;
`ifdef UART_TX_PARITY_EN
      parity <= parity_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx at default rate (M=868) and a fast instance (M=16).
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int MA = 868;
  localparam int MB = 16;
  typedef struct {logic [7:0] d; logic p;} vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst, a_valid, a_ready, a_busy, a_tx, b_rst, b_valid, b_ready, b_busy, b_tx;
  logic [7:0] a_data, b_data;
  logic [2:0] a_state, b_state;
  int tests = 0, fails = 0;
  uart_tx dut_a (.clk(clk), .reset(a_rst), .tx_data(a_data), .tx_data_valid(a_valid),
    .tx_data_ready(a_ready), .tx_busy(a_busy), .UART_TX(a_tx), .current_state_debug(a_state));
  uart_tx #(.CLOCKRATE(16), .BAUD(1)) dut_b (.clk(clk), .reset(b_rst), .tx_data(b_data),
    .tx_data_valid(b_valid), .tx_data_ready(b_ready), .tx_busy(b_busy), .UART_TX(b_tx),
    .current_state_debug(b_state));
  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int i);
    return i == 0 ? 1'b0 : i < 9 ? d[i-1] : (i == 9 && NB == 11) ? p : 1'b1;
  endfunction
  // Starts on the first cycle of the start bit and returns on the first cycle after the frame
  task automatic run_frame(input bit sel, input string nm, input logic [7:0] d, input logic p, output int busy);
    int ok, s3, m;
    busy = 0;
    s3 = 0;
    m = sel ? MB : MA;
    for (int i = 0; i < NB; i++) begin
      ok = 0;
      for (int c = 0; c < m; c++) begin
        ok += int'((sel ? b_tx : a_tx) === exp_bit(d, p, i));
        busy += int'(sel ? b_busy : a_busy);
        s3 += int'((sel ? b_state : a_state) == 3'd3);
        tick();
      end
      check($sformatf("%s bit%0d cycles", nm, i), ok, m);
    end
    check($sformatf("%s parity-state cycles", nm), s3, NB == 11 ? m : 0);
  endtask
  task automatic wait_start(input string nm);
    int w = 0;
    while (b_tx !== 1'b0 && w < 100) begin
      tick();
      w++;
    end
    check($sformatf("%s start seen", nm), int'(b_tx), 0);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl[7];
    vec_t inc[5];
    int bz, total;
    tbl = '{'{8'h55, 1'b0}, '{8'h3C, 1'b0}, '{8'h00, 1'b0}, '{8'hFF, 1'b0},
            '{8'h81, 1'b0}, '{8'hA7, 1'b1}, '{8'h01, 1'b1}};
    inc = '{'{8'h10, 1'b1}, '{8'h11, 1'b0}, '{8'h12, 1'b0}, '{8'h13, 1'b1}, '{8'h14, 1'b0}};
    a_rst = 0; b_rst = 0; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0;
    repeat (3) tick();
    check("reset ready a", int'(a_ready), 0);
    check("reset tx a", int'(a_tx), 1);
    check("reset state a", int'(a_state), 0);
    check("reset busy a", int'(a_busy), 0);
    check("reset ready b", int'(b_ready), 0);
    a_rst = 1; b_rst = 1;
    tick();
    check("release ready a", int'(a_ready), 1);
    check("release ready b", int'(b_ready), 1);
    check("release tx b", int'(b_tx), 1);
    // 0xA7 at the default bit period with exact launch latency
    a_data = 8'hA7; a_valid = 1;
    tick();
    a_valid = 0; a_data = 8'h00;
    check("t1 tx after N", int'(a_tx), 1);
    check("t1 ready after N", int'(a_ready), 0);
    tick();
    check("t1 tx after N+1", int'(a_tx), 0);
    check("t1 ready after N+1", int'(a_ready), 1);
    run_frame(0, "t1 A7", 8'hA7, 1'b1, bz);
    check("t1 busy clocks", bz, NB * MA);
    check("t1 idle tx", int'(a_tx), 1);
    check("t1 idle state", int'(a_state), 0);
    check("t1 idle busy", int'(a_busy), 0);
    // back-to-back table: each later word offered during the previous frame's DATA
    total = 0;
    fork
      begin
        int w;
        for (int i = 0; i < 7; i++) begin
          if (i > 0) begin
            w = 0;
            while (b_state != 3'd1 && w < 400) begin tick(); w++; end
            while (b_state != 3'd2 && w < 800) begin tick(); w++; end
            check($sformatf("t2 word%0d offered in DATA", i), int'(b_state), 2);
          end
          b_data = tbl[i].d; b_valid = 1;
          w = 0;
          while (!b_ready && w < 400) begin tick(); w++; end
          check($sformatf("t2 word%0d ready", i), int'(b_ready), 1);
          tick();
          b_valid = 0; b_data = ~tbl[i].d;
        end
      end
      begin
        wait_start("t2");
        for (int i = 0; i < 7; i++) begin
          run_frame(1, $sformatf("t2 frame%0d", i), tbl[i].d, tbl[i].p, bz);
          total += bz;
        end
        check("t2 busy clocks", total, 7 * NB * MB);
        check("t2 idle tx", int'(b_tx), 1);
        check("t2 idle state", int'(b_state), 0);
      end
    join
    // reset during DATA bit 3 of 0xF0 with a second word already held
    b_data = 8'hF0; b_valid = 1;
    tick();
    b_valid = 0;
    tick();
    repeat (4 * MB + MB / 2) tick();
    check("t4 in DATA", int'(b_state), 2);
    check("t4 bit3 value", int'(b_tx), 0);
    b_data = 8'h99; b_valid = 1;
    check("t4 hold accepts", int'(b_ready), 1);
    tick();
    b_valid = 0;
    b_rst = 0;
    tick();
    check("t4 reset tx", int'(b_tx), 1);
    check("t4 reset state", int'(b_state), 0);
    check("t4 reset ready", int'(b_ready), 0);
    b_rst = 1;
    #1;
    check("t4 release ready", int'(b_ready), 1);
    repeat (3) tick();
    check("t4 held word dropped busy", int'(b_busy), 0);
    check("t4 held word dropped tx", int'(b_tx), 1);
    b_data = 8'h12; b_valid = 1;
    tick();
    b_valid = 0;
    tick();
    run_frame(1, "t4 12", 8'h12, 1'b0, bz);
    check("t4 after 12 state", int'(b_state), 0);
    // valid held high with incrementing data: five contiguous frames
    b_data = 8'h10; b_valid = 1;
    fork
      begin
        int w = 0, acc = 0;
        logic h;
        while (acc < 5 && w < 5000) begin
          h = b_valid && b_ready;
          tick();
          if (h) begin acc++; b_data = b_data + 8'd1; end
          w++;
        end
        b_valid = 0;
        check("t6 words accepted", acc, 5);
      end
      begin
        wait_start("t6");
        for (int i = 0; i < 5; i++)
          run_frame(1, $sformatf("t6 frame%0d", i), inc[i].d, inc[i].p, bz);
        check("t6 idle state", int'(b_state), 0);
        check("t6 idle tx", int'(b_tx), 1);
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
